// File: rtl/strb_scheduler_pkg.sv
// Shared defaults for the strobe scheduler and its round-robin arbiter.
package strb_scheduler_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned DW_DEF = 8;

endpackage : strb_scheduler_pkg

// File: rtl/strb_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping mod N.
module rr_arbiter
  import strb_scheduler_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_sel_c,
  output logic [PW-1:0] o_idx_c,
  output logic          o_valid_c
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    logic [PW-1:0] v_idx;
    int            v_pos;
    o_sel_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    v_idx     = '0;
    v_pos     = 0;
    for (int k = 0; k < int'(N); k++) begin
      v_pos = (int'(i_ptr) + k) % int'(N);
      v_idx = PW'(v_pos);
      if (!o_valid_c && i_req[v_idx]) begin
        o_valid_c      = 1'b1;
        o_sel_c[v_idx] = 1'b1;
        o_idx_c        = v_idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/strb_scheduler.sv
// Divides a shared base tick per channel and serialises expirations onto one
// downstream resource via round-robin one-hot grants. Also pulses the strobe
// generator's sync reset when the first channel is enabled.
module strb_scheduler
  import strb_scheduler_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic            nrstSync_i,
  input  logic            tick_i,
  input  logic [N-1:0]    en_i,
  input  logic [N*DW-1:0] div_i,
  input  logic            busy_i,
  input  logic [N-1:0]    ovrClr_i,
  output logic [N-1:0]    gnt_o,
  output logic [N-1:0]    ovr_o,
  output logic            genRst_o
);

  logic [N-1:0]  w_pend;
  logic [N-1:0]  w_ovr;
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_sel;
  logic [PW-1:0] w_idx;
  logic          w_valid;
  logic          w_en_any;

  logic [N-1:0]  r_gnt;
  logic [PW-1:0] r_ptr;
  logic          r_gen_rst;
  logic          r_en_any;

  // Disabled channels and a busy resource never request.
  assign w_req    = busy_i ? '0 : (w_pend & en_i);
  assign w_en_any = |en_i;

  rr_arbiter #(.N(N)) u_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_sel_c   (w_sel),
    .o_idx_c   (w_idx),
    .o_valid_c (w_valid)
  );

  // Per-channel divider, pending flag and sticky overrun.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_ch
    logic [DW-1:0] r_cnt;
    logic          r_pend;
    logic          r_ovr;
    logic [DW-1:0] w_div;
    logic          w_expire;
    logic          w_granted;

    assign w_div     = div_i[gi*DW +: DW];
    // >= lets a lowered divide value expire on the next tick instead of wrapping.
    assign w_expire  = en_i[gi] & tick_i & (r_cnt >= w_div);
    assign w_granted = w_sel[gi];

    // Count ticks, latch expirations, flag expirations that land on an ungranted pend.
    always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (!nrstSync_i || !en_i[gi]) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end else begin
        if (tick_i) begin
          r_cnt <= w_expire ? '0 : r_cnt + DW'(1);
        end
        r_pend <= w_expire | (r_pend & ~w_granted);
        if (w_expire && r_pend && !w_granted) begin
          r_ovr <= 1'b1;
        end else if (ovrClr_i[gi]) begin
          r_ovr <= 1'b0;
        end
      end
    end

    assign w_pend[gi] = r_pend;
    assign w_ovr[gi]  = r_ovr;
  end

  // Grant register, rotating pointer and generator-alignment pulse.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_gen_rst <= 1'b1;
      r_en_any  <= 1'b0;
    end else if (!nrstSync_i) begin
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_gen_rst <= 1'b0;
      r_en_any  <= 1'b0;
    end else begin
      r_gnt <= w_sel;
      if (w_valid) begin
        r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
      end
      r_gen_rst <= ~(w_en_any & ~r_en_any);
      r_en_any  <= w_en_any;
    end
  end

  assign gnt_o    = r_gnt;
  assign ovr_o    = w_ovr;
  assign genRst_o = r_gen_rst;

endmodule : strb_scheduler
